// File: rtl/dlfloat_mul_arbiter.sv
// dlfloat_mul_arbiter
//   Shares one combinational DLFloat16 multiplier between NREQ requesters.
//   A round-robin arbiter picks a requester while idle, its operands are
//   registered onto mul_a/mul_b, the product on mul_sum is captured after
//   MUL_LAT cycles and handed back over a per-requester valid/ready pair.
//   No floating-point math happens here; mul_sum is passed through verbatim.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   req_valid/req_ready     per-requester operand handshake (ready one-hot)
//   req_a/req_b             packed operands, requester i at [16i+15:16i]
//   resp_valid/resp_ready   per-requester result handshake (valid one-hot)
//   resp_data/resp_id       captured product and owning requester index
//   mul_a/mul_b/mul_sum     registered operands to / result from the multiplier
//   busy                    high while an operation is in flight
//   ops_done                wrapping count of completed response handshakes
module dlfloat_mul_arbiter #(
  parameter int NREQ    = 2,
  parameter int MUL_LAT = 1,
  parameter int IDW     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [15:0]          resp_data,
  output logic [IDW-1:0]       resp_id,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [15:0]          mul_sum,
  output logic                 busy,
  output logic [15:0]          ops_done
);

  localparam int LW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      last_grant;
  logic [LW-1:0]       lat_cnt;
  logic [15:0]         ops_done_q;

  logic [2*NREQ-1:0]   vld_dbl;
  logic [NREQ-1:0]     vld_rot;
  logic                gnt_found;
  logic [IDW-1:0]      gnt_idx;
  logic [15:0]         sel_a, sel_b;
  logic                req_hs, resp_hs, cap;

  // Stage: round-robin arbitration (search starts just after last_grant)
  always_comb begin
    // Doubling the vector lets a plain shift perform the modulo rotation.
    vld_dbl   = {req_valid, req_valid};
    vld_rot   = NREQ'(vld_dbl >> (last_grant + IDW'(1)));
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!gnt_found && vld_rot[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'((int'(last_grant) + 1 + j) % NREQ);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (gnt_idx == IDW'(j)) begin
        sel_a = req_a[16*j +: 16];
        sel_b = req_b[16*j +: 16];
      end
    end
  end

  assign req_hs     = (state_q == IDLE) && gnt_found;
  // rst_n gating keeps req_ready low while reset is held, even with requests pending.
  assign req_ready  = (rst_n && req_hs) ? (NREQ'(1) << gnt_idx) : '0;
  assign resp_valid = (state_q == RESP) ? (NREQ'(1) << resp_id) : '0;
  assign resp_hs    = (state_q == RESP) && |(resp_ready & resp_valid);
  assign cap        = (state_q == EXEC) && (lat_cnt == LW'(1));
  assign busy       = (state_q != IDLE);
  assign ops_done   = ops_done_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_hs)  state_d = EXEC;
      EXEC:    if (cap)     state_d = RESP;
      RESP:    if (resp_hs) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Stage: control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_grant <= IDW'(NREQ - 1);
      lat_cnt    <= '0;
      ops_done_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        last_grant <= gnt_idx;
        lat_cnt    <= LW'(MUL_LAT);
      end else if (state_q == EXEC) begin
        lat_cnt <= lat_cnt - LW'(1);
      end
      if (resp_hs) ops_done_q <= ops_done_q + 16'd1;
    end
  end

  // Stage: operand and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a     <= '0;
      mul_b     <= '0;
      resp_id   <= '0;
      resp_data <= '0;
    end else begin
      if (req_hs) begin
        mul_a   <= sel_a;
        mul_b   <= sel_b;
        resp_id <= gnt_idx;
      end
      // Sampled only on the last EXEC cycle so earlier multiplier glitches are ignored.
      if (cap) resp_data <= mul_sum;
    end
  end

endmodule
